// File: rtl/sbm_chk_pkg.sv
// Shared types and helpers for the a->c response checker.
package sbm_chk_pkg;

    // Per-channel checker state
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chan_state_e;

    // Stimulus pair value that arms a channel unless overridden
    localparam logic [1:0] TRIG_DEFAULT = 2'b11;

    // Add inc to cur, clamping the result at max_val
    function automatic logic [31:0] sat_add(input logic [31:0] cur,
                                            input logic [31:0] inc,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, cur} + {1'b0, inc};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/sbm_chk_chan.sv
// Single-channel trigger/response checker: FSM plus latency counter.
// viol_c is combinational and pulses on the sample that detects a
// timeout or a spurious c_1.
module sbm_chk_chan
    import sbm_chk_pkg::*;
#(
    parameter int unsigned MAX_LAT = 4,
    parameter logic [1:0]  TRIG    = TRIG_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] a,
    input  logic [1:0] c,
    output logic       busy,
    output logic       viol_c
);

    localparam int unsigned LAT_W = $clog2(MAX_LAT + 1);

    chan_state_e      state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;

    // State and latency registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state, latency update and violation detection
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        viol_c  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            lat_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (a == TRIG) begin
                        state_d = WAIT;
                        lat_d   = LAT_W'(1);
                    end
                end
                WAIT: begin
                    if (c[0]) begin
                        // pass; the same cycle may re-arm
                        if (a == TRIG) begin
                            state_d = WAIT;
                            lat_d   = LAT_W'(1);
                        end else begin
                            state_d = IDLE;
                            lat_d   = '0;
                        end
                    end else if (c[1]) begin
                        viol_c  = 1'b1;
                        state_d = IDLE;
                        lat_d   = '0;
                    end else if (lat_q == LAT_W'(MAX_LAT)) begin
                        viol_c  = 1'b1;
                        state_d = IDLE;
                        lat_d   = '0;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    lat_d   = '0;
                end
            endcase
        end
    end

    assign busy = (state_q == WAIT);

endmodule

// File: rtl/sbm_response_checker.sv
// Multi-channel a->c response checker: per-channel FSMs plus sticky
// error flags, saturating violation count and first-failure capture.
// Optional SBM_CHK_TIMESTAMP_EN adds a free-running cycle counter and
// the first_ts output latched with the first failing channel.
module sbm_response_checker
    import sbm_chk_pkg::*;
#(
    parameter int unsigned NCH     = 10,
    parameter int unsigned MAX_LAT = 4,
    parameter logic [1:0]  TRIG    = TRIG_DEFAULT,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [2*NCH-1:0] a,
    input  logic [2*NCH-1:0] c,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   err,
    output logic             any_err,
    output logic [CH_W-1:0]  first_ch,
    output logic             first_vld,
`ifdef SBM_CHK_TIMESTAMP_EN
    output logic [31:0]      first_ts,
`endif
    output logic [CNT_W-1:0] viol_cnt
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [NCH-1:0]   viol_c;
    logic [NCH-1:0]   err_q, err_d;
    logic             any_err_q, any_err_d;
    logic [CH_W-1:0]  first_ch_q, first_ch_d;
    logic             first_vld_q, first_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      n_viol_c;
    logic [CH_W-1:0]  first_idx_c;

    // One checker per channel
    for (genvar k = 0; k < NCH; k++) begin : g_chan
        sbm_chk_chan #(
            .MAX_LAT (MAX_LAT),
            .TRIG    (TRIG)
        ) u_chan (
            .clock   (clock),
            .reset_n (reset_n),
            .enable  (enable),
            .a       (a[2*k +: 2]),
            .c       (c[2*k +: 2]),
            .busy    (busy[k]),
            .viol_c  (viol_c[k])
        );
    end

    // Violation population count and lowest violating index
    always_comb begin
        n_viol_c    = '0;
        first_idx_c = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            n_viol_c = n_viol_c + 32'(viol_c[k]);
        end
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            if (viol_c[k]) begin
                first_idx_c = CH_W'(k);
            end
        end
    end

`ifdef SBM_CHK_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, ts_cnt_d;
    logic [31:0] first_ts_q, first_ts_d;

    // Free-running cycle counter, wraps at 2^32
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
        end
    end

    assign ts_cnt_d = ts_cnt_q + 32'd1;
    assign first_ts = first_ts_q;
`endif

    // Aggregation next-state: sticky flags, count, first-failure capture
    always_comb begin
        err_d       = err_q | viol_c;
        cnt_d       = CNT_W'(sat_add(32'(cnt_q), n_viol_c, CNT_MAX));
        first_ch_d  = first_ch_q;
        first_vld_d = first_vld_q;
`ifdef SBM_CHK_TIMESTAMP_EN
        first_ts_d  = first_ts_q;
`endif
        if (!first_vld_q && (|viol_c)) begin
            first_ch_d  = first_idx_c;
            first_vld_d = 1'b1;
`ifdef SBM_CHK_TIMESTAMP_EN
            first_ts_d  = ts_cnt_q;
`endif
        end
        // clear wins over anything detected in the same cycle
        if (clear) begin
            err_d       = '0;
            cnt_d       = '0;
            first_ch_d  = '0;
            first_vld_d = 1'b0;
`ifdef SBM_CHK_TIMESTAMP_EN
            first_ts_d  = '0;
`endif
        end
        any_err_d = |err_d;
    end

    // Aggregation registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q       <= '0;
            any_err_q   <= 1'b0;
            cnt_q       <= '0;
            first_ch_q  <= '0;
            first_vld_q <= 1'b0;
`ifdef SBM_CHK_TIMESTAMP_EN
            first_ts_q  <= '0;
`endif
        end else begin
            err_q       <= err_d;
            any_err_q   <= any_err_d;
            cnt_q       <= cnt_d;
            first_ch_q  <= first_ch_d;
            first_vld_q <= first_vld_d;
`ifdef SBM_CHK_TIMESTAMP_EN
            first_ts_q  <= first_ts_d;
`endif
        end
    end

    assign err       = err_q;
    assign any_err   = any_err_q;
    assign viol_cnt  = cnt_q;
    assign first_ch  = first_ch_q;
    assign first_vld = first_vld_q;

endmodule
